rvm_shift_ctrl: RTL
===================

Name: rvm_shift_ctrl

Overview:
- Sequential issue/capture stage wrapped around the combinational 32-bit shifter in the multi-cycle core.
- Accepts a decoded shift request (SLL/SRL/SRA and the SLLI/SRLI/SRAI immediate forms) from the control FSM.
- Latches the operands, drives the shifter's lhs/rhs/op inputs for a configurable number of cycles, then captures the result into a register.
- Presents that result to register writeback with a valid/ready handshake.

Parameters:
- EXEC_CYCLES, 1, number of cycles the shifter inputs are held stable before the result is captured (1..15).

Ports:
- clk  input  1  core clock; all state changes on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  stage can accept a request.
- req_funct3  input  3  instruction funct3.
- req_funct7_5  input  1  instruction bit 30.
- req_imm  input  1  1 = immediate form; shift amount comes from req_shamt.
- req_rs1  input  32  source register 1 value.
- req_rs2  input  32  source register 2 value; only bits [4:0] are used.
- req_shamt  input  5  immediate shift amount.
- req_rd  input  5  destination register index.
- shf_lhs  output  32  shifter left-hand operand.
- shf_rhs  output  5  shifter shift amount.
- shf_op  output  2  shifter op: 00 NOP, 01 SLL, 10 SRL, 11 SRA.
- shf_valid  input  1  shifter result-valid.
- shf_result  input  33  shifter result; only bits [31:0] are used.
- wb_valid  output  1  result available for writeback.
- wb_ready  input  1  writeback accepts the result.
- wb_data  output  32  captured result.
- wb_rd  output  5  destination register index.
- wb_err  output  1  1 = illegal encoding or missing shf_valid; the result must not be written.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE.
  - req_ready=1, wb_valid=0, wb_data=0, wb_rd=0, wb_err=0.
  - shf_op=00, shf_lhs=0, shf_rhs=0, internal counter=0.
  - Assertion mid-operation aborts immediately; the in-flight request is lost.
- Decode, evaluated at acceptance:
  - funct3=001 & f7_5=0 -> SLL.
  - funct3=101 & f7_5=0 -> SRL.
  - funct3=101 & f7_5=1 -> SRA.
  - Anything else -> illegal.
  - Shift amount = req_imm ? req_shamt : req_rs2[4:0].
- States: IDLE, EXEC, RESP.
- IDLE:
  - req_ready=1; shf_op=00 and shf_lhs/shf_rhs=0, so the shifter stays isolated.
  - On req_valid, latch the op, rs1, shift amount and rd.
  - Legal request -> EXEC with counter=0.
  - Illegal request -> RESP with wb_err=1, wb_data=0.
- EXEC:
  - req_ready=0. shf_op, shf_lhs and shf_rhs are driven from the latched values and held constant.
  - The counter increments each cycle.
  - When counter==EXEC_CYCLES-1: capture wb_data=shf_result[31:0] and wb_err=~shf_valid, then -> RESP.
- RESP:
  - wb_valid=1; req_ready=0; shf_op=00.
  - wb_data, wb_rd and wb_err hold until wb_ready=1.
  - When wb_ready=1 that cycle: -> IDLE, wb_valid=0 next cycle.
- Latency, legal request:
  - Accepted at edge N; wb_valid high from edge N+1+EXEC_CYCLES.
  - EXEC_CYCLES=1: 2 cycles request-to-writeback-valid.
- Illegal request: wb_valid high from edge N+1.
- No overlap: a request presented in RESP is not accepted, even when wb_ready=1 in the same cycle. It is accepted in IDLE one cycle later at the earliest.
- wb_ready while wb_valid=0 is ignored.
- rd=0 gets no special treatment; writeback discards x0.

Test Plan:
- Reset, then req SLL, rs1=0x0000_0001, rs2=0x0000_0024 (amount 4), rd=5 -> shf_op=01, shf_rhs=4 for one cycle; wb_valid 2 cycles after accept with wb_data=0x0000_0010, wb_rd=5, wb_err=0.
- SRAI, f7_5=1, shamt=31, rs1=0x8000_0000 -> wb_data=0xFFFF_FFFF. SRL with the same operands and amount -> wb_data=0x0000_0001.
- Illegal: funct3=001, f7_5=1 -> no EXEC cycle, shf_op stays 00, wb_valid next cycle with wb_err=1, wb_data=0.
- Backpressure: hold wb_ready=0 for 5 cycles with a new req_valid pending -> wb_data stable, req_ready=0 throughout. Release wb_ready -> IDLE, then the pending request is accepted the following cycle.
- EXEC_CYCLES=3 with shf_valid forced low -> shifter inputs stable for 3 cycles, then wb_err=1.
- Assert resetn=0 during EXEC -> all outputs return to reset values asynchronously; after release req_ready=1 and no stale wb_valid appears.

Source files
------------

// File: rtl/rvm_shift_ctrl.sv
// Issue/capture stage around the combinational 32-bit shifter.
// Accepts a decoded shift request and latches its operands. It holds the
// shifter inputs stable for EXEC_CYCLES cycles, captures the result, and
// offers it to writeback under a valid/ready handshake.
module rvm_shift_ctrl #(
  parameter int unsigned EXEC_CYCLES = 1   // 1..15
) (
  input  logic        clk,
  input  logic        resetn,
  // request side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic        req_funct7_5,
  input  logic        req_imm,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_shamt,
  input  logic [4:0]  req_rd,
  // shifter side
  output logic [31:0] shf_lhs,
  output logic [4:0]  shf_rhs,
  output logic [1:0]  shf_op,
  input  logic        shf_valid,
  input  logic [32:0] shf_result,
  // writeback side
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRL = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  // Last counter value of the hold window; the result is captured on it.
  localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [4:0]  r_rd;

  logic [1:0]  w_op;
  logic        w_legal;
  logic [4:0]  w_amt;
  // Bits the stage deliberately ignores: the shifter's carry-out bit and
  // the upper part of rs2.
  logic        w_unused;

  assign w_unused = ^{shf_result[32], req_rs2[31:5]};

  // Decode the incoming request into a shifter op and a shift amount.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_op = OP_NOP;
    if (req_funct3 == 3'b001 && !req_funct7_5) begin
      w_op = OP_SLL;
    end else if (req_funct3 == 3'b101) begin
      w_op = req_funct7_5 ? OP_SRA : OP_SRL;
    end
    w_legal = (w_op != OP_NOP);
    w_amt   = req_imm ? req_shamt : req_rs2[4:0];
  end

  // Control FSM. Every output is registered, so the shifter sees clean and stable inputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: every datapath register is cleared too, so nothing stale is visible after an abort.
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rd      <= '0;
      req_ready <= 1'b1;
      shf_op    <= OP_NOP;
      shf_lhs   <= '0;
      shf_rhs   <= '0;
      wb_valid  <= 1'b0;
      wb_data   <= '0;
      wb_rd     <= '0;
      wb_err    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            r_rd      <= req_rd;
            if (w_legal) begin
              shf_op  <= w_op;
              shf_lhs <= req_rs1;
              shf_rhs <= w_amt;
              r_cnt   <= '0;
              r_state <= S_EXEC;
            end else begin
              // An illegal encoding never reaches the shifter.
              wb_valid <= 1'b1;
              wb_err   <= 1'b1;
              wb_data  <= '0;
              wb_rd    <= req_rd;
              r_state  <= S_RESP;
            end
          end
        end

        S_EXEC: begin
          if (r_cnt == LAST_CNT) begin
            wb_data  <= shf_result[31:0];
            wb_err   <= ~shf_valid;
            wb_rd    <= r_rd;
            wb_valid <= 1'b1;
            shf_op   <= OP_NOP;
            shf_lhs  <= '0;
            shf_rhs  <= '0;
            r_cnt    <= '0;
            r_state  <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end

        S_RESP: begin
          // The stage returns to IDLE first, so a new request cannot overlap the handshake.
          if (wb_ready) begin
            wb_valid  <= 1'b0;
            req_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
